// File: rtl/axi_mon_pkg.sv
// Shared constants for the AXI transaction monitor: error vector layout.
package axi_mon_pkg;
  localparam int ERR_W              = 7;
  localparam int ERR_WLAST_EARLY    = 0;
  localparam int ERR_WLAST_MISSING  = 1;
  localparam int ERR_W_NO_AW        = 2;
  localparam int ERR_BID_UNEXP      = 3;
  localparam int ERR_RID_UNEXP      = 4;
  localparam int ERR_RLAST_MISMATCH = 5;
  localparam int ERR_OVERFLOW       = 6;

  typedef logic [ERR_W-1:0] err_vec_t;
endpackage

// File: rtl/axi_txn_monitor_if.sv
// AXI4 control-signal probe bundle; the monitor only ever sees the slave (input) view.
interface axi_txn_monitor_if #(
  parameter int ID_W  = 4,
  parameter int LEN_W = 8
) ();
  logic             awvalid, awready;
  logic [ID_W-1:0]  awid;
  logic [LEN_W-1:0] awlen;
  logic             wvalid, wready, wlast;
  logic             bvalid, bready;
  logic [ID_W-1:0]  bid;
  logic             arvalid, arready;
  logic [ID_W-1:0]  arid;
  logic [LEN_W-1:0] arlen;
  logic             rvalid, rready, rlast;
  logic [ID_W-1:0]  rid;

  modport master (output awvalid, awready, awid, awlen, wvalid, wready, wlast,
                  bvalid, bready, bid, arvalid, arready, arid, arlen,
                  rvalid, rready, rlast, rid);
  modport slave  (input  awvalid, awready, awid, awlen, wvalid, wready, wlast,
                  bvalid, bready, bid, arvalid, arready, arid, arlen,
                  rvalid, rready, rlast, rid);
endinterface

// File: rtl/axi_len_fifo.sv
// Small circular buffer of burst lengths; push while full and pop while empty are ignored.
module axi_len_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PW-1:0]               rd_q, wr_q;
  logic [CW-1:0]               cnt_q;
  logic                        do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din;
        wr_q        <= nxt(wr_q);
      end
      if (do_pop) rd_q <= nxt(rd_q);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/axi_txn_monitor.sv
// Passive AXI4 monitor: tracks outstanding bursts, checks beat counts, flags sticky errors.
module axi_txn_monitor
  import axi_mon_pkg::*;
#(
  parameter int ID_W      = 4,
  parameter int LEN_W     = 8,
  parameter int WR_OUTS   = 8,
  parameter int RD_PER_ID = 4,
  localparam int NID  = 2**ID_W,
  localparam int WO_W = $clog2(WR_OUTS + 1),
  localparam int RO_W = $clog2(RD_PER_ID * NID + 1)
) (
  input  logic             aclk,
  input  logic             aresetn,
  axi_txn_monitor_if.slave bus,
  input  logic             err_clear,
  output logic [ERR_W-1:0] err,
  output logic             err_pulse,
  output logic [WO_W-1:0]  wr_outs,
  output logic [RO_W-1:0]  rd_outs,
  output logic             wr_done,
  output logic             rd_done
);
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  assign aw_hs = bus.awvalid & bus.awready;
  assign w_hs  = bus.wvalid  & bus.wready;
  assign b_hs  = bus.bvalid  & bus.bready;
  assign ar_hs = bus.arvalid & bus.arready;
  assign r_hs  = bus.rvalid  & bus.rready;

  // Write path: one in-order length FIFO shared by all IDs.
  logic             wf_full, wf_empty, wf_push, wf_pop;
  logic [LEN_W-1:0] wf_head;
  assign wf_push = aw_hs & ~wf_full;

  axi_len_fifo #(.DEPTH(WR_OUTS), .WIDTH(LEN_W)) u_wfifo (
    .clk(aclk), .rst_n(aresetn), .push(wf_push), .pop(wf_pop), .din(bus.awlen),
    .full(wf_full), .empty(wf_empty), .head(wf_head)
  );

  // Read path: one length buffer per ID so interleaved responses stay separable.
  logic [NID-1:0]            rd_full, rd_empty, rd_push, rd_pop;
  logic [NID-1:0][LEN_W-1:0] rd_head;

  for (genvar g = 0; g < NID; g++) begin : g_rbuf
    axi_len_fifo #(.DEPTH(RD_PER_ID), .WIDTH(LEN_W)) u_rfifo (
      .clk(aclk), .rst_n(aresetn), .push(rd_push[g]), .pop(rd_pop[g]), .din(bus.arlen),
      .full(rd_full[g]), .empty(rd_empty[g]), .head(rd_head[g])
    );
  end

  logic [LEN_W-1:0]          wbeat_q, wbeat_d;
  logic [NID-1:0][LEN_W-1:0] rbeat_q, rbeat_d;
  logic [NID-1:0][WO_W-1:0]  bpend_q, bpend_d;
  logic [WO_W-1:0]           wr_outs_q, wr_outs_d;
  logic [RO_W-1:0]           rd_outs_q, rd_outs_d;
  err_vec_t                  err_q, err_d, err_set;
  logic                      err_pulse_q, wr_done_q, rd_done_q;
  logic                      b_ok, r_done;

  assign b_ok = b_hs && (bpend_q[bus.bid] != '0);

  always_comb begin
    err_set = '0;
    wf_pop  = 1'b0;
    wbeat_d = wbeat_q;
    rd_push = '0;
    rd_pop  = '0;
    rbeat_d = rbeat_q;
    r_done  = 1'b0;
    if (aw_hs && wf_full) err_set[ERR_OVERFLOW] = 1'b1;
    if (ar_hs && rd_full[bus.arid]) err_set[ERR_OVERFLOW] = 1'b1;
    if (b_hs && !b_ok) err_set[ERR_BID_UNEXP] = 1'b1;

    // wbeat never exceeds the head length, so wlast or reaching len always ends the burst.
    if (w_hs) begin
      if (wf_empty) err_set[ERR_W_NO_AW] = 1'b1;
      else if (bus.wlast || wbeat_q == wf_head) begin
        wf_pop  = 1'b1;
        wbeat_d = '0;
        if (bus.wlast && wbeat_q != wf_head) err_set[ERR_WLAST_EARLY] = 1'b1;
        if (!bus.wlast) err_set[ERR_WLAST_MISSING] = 1'b1;
      end else wbeat_d = wbeat_q + LEN_W'(1);
    end

    for (int i = 0; i < NID; i++) begin
      rd_push[i] = ar_hs && (bus.arid == ID_W'(i)) && !rd_full[i];
      bpend_d[i] = bpend_q[i] + WO_W'(wf_push && bus.awid == ID_W'(i))
                              - WO_W'(b_ok && bus.bid == ID_W'(i));
    end

    if (r_hs) begin
      if (rd_empty[bus.rid]) err_set[ERR_RID_UNEXP] = 1'b1;
      else if (bus.rlast != (rbeat_q[bus.rid] == rd_head[bus.rid])) begin
        err_set[ERR_RLAST_MISMATCH] = 1'b1;
        rd_pop[bus.rid]  = 1'b1;
        rbeat_d[bus.rid] = '0;
      end else if (bus.rlast) begin
        rd_pop[bus.rid]  = 1'b1;
        rbeat_d[bus.rid] = '0;
        r_done           = 1'b1;
      end else rbeat_d[bus.rid] = rbeat_q[bus.rid] + LEN_W'(1);
    end

    wr_outs_d = wr_outs_q + WO_W'(wf_push) - WO_W'(b_ok);
    rd_outs_d = rd_outs_q + RO_W'(|rd_push) - RO_W'(|rd_pop);
    err_d     = (err_clear ? '0 : err_q) | err_set;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wbeat_q     <= '0;
      rbeat_q     <= '0;
      bpend_q     <= '0;
      wr_outs_q   <= '0;
      rd_outs_q   <= '0;
      err_q       <= '0;
      err_pulse_q <= 1'b0;
      wr_done_q   <= 1'b0;
      rd_done_q   <= 1'b0;
    end else begin
      wbeat_q     <= wbeat_d;
      rbeat_q     <= rbeat_d;
      bpend_q     <= bpend_d;
      wr_outs_q   <= wr_outs_d;
      rd_outs_q   <= rd_outs_d;
      err_q       <= err_d;
      err_pulse_q <= |(err_set & ~err_q);
      wr_done_q   <= b_ok;
      rd_done_q   <= r_done;
    end
  end

  assign err       = err_q;
  assign err_pulse = err_pulse_q;
  assign wr_outs   = wr_outs_q;
  assign rd_outs   = rd_outs_q;
  assign wr_done   = wr_done_q;
  assign rd_done   = rd_done_q;
endmodule

// File: tb/tb_axi_txn_monitor.sv
// Directed bench for axi_txn_monitor: hand-computed expectations per scenario.
module tb_axi_txn_monitor;
  logic       aclk, aresetn, err_clear;
  logic [6:0] err;
  logic       err_pulse, wr_done, rd_done;
  logic [3:0] wr_outs;
  logic [6:0] rd_outs;
  int passed = 0;
  int total  = 0;

  axi_txn_monitor_if #(.ID_W(4), .LEN_W(8)) bus ();

  axi_txn_monitor #(.ID_W(4), .LEN_W(8), .WR_OUTS(8), .RD_PER_ID(4)) dut (
    .aclk(aclk), .aresetn(aresetn), .bus(bus), .err_clear(err_clear),
    .err(err), .err_pulse(err_pulse), .wr_outs(wr_outs), .rd_outs(rd_outs),
    .wr_done(wr_done), .rd_done(rd_done)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic cyc();
    @(posedge aclk); #1;
  endtask

  task automatic idle();
    bus.awvalid = 0; bus.awready = 0; bus.awid = 0; bus.awlen = 0;
    bus.wvalid = 0; bus.wready = 0; bus.wlast = 0;
    bus.bvalid = 0; bus.bready = 0; bus.bid = 0;
    bus.arvalid = 0; bus.arready = 0; bus.arid = 0; bus.arlen = 0;
    bus.rvalid = 0; bus.rready = 0; bus.rlast = 0; bus.rid = 0;
    err_clear = 0;
  endtask

  task automatic aw(input logic [3:0] id, input logic [7:0] len);
    bus.awvalid = 1; bus.awready = 1; bus.awid = id; bus.awlen = len;
  endtask
  task automatic wb(input logic last);
    bus.wvalid = 1; bus.wready = 1; bus.wlast = last;
  endtask
  task automatic b(input logic [3:0] id);
    bus.bvalid = 1; bus.bready = 1; bus.bid = id;
  endtask
  task automatic ar(input logic [3:0] id, input logic [7:0] len);
    bus.arvalid = 1; bus.arready = 1; bus.arid = id; bus.arlen = len;
  endtask
  task automatic r(input logic [3:0] id, input logic last);
    bus.rvalid = 1; bus.rready = 1; bus.rid = id; bus.rlast = last;
  endtask
  task automatic clr();
    err_clear = 1; cyc(); err_clear = 0;
  endtask

  task automatic test_reset();
    idle(); aresetn = 0; cyc(); cyc();
    total++; if (err !== 7'h00) $display("FAIL rst_err got %0h exp 0", err); else passed++;
    total++; if (err_pulse !== 1'b0) $display("FAIL rst_pulse got %0b exp 0", err_pulse); else passed++;
    total++; if (wr_outs !== 4'd0 || rd_outs !== 7'd0) $display("FAIL rst_outs got %0d/%0d exp 0/0", wr_outs, rd_outs); else passed++;
    total++; if (wr_done !== 1'b0 || rd_done !== 1'b0) $display("FAIL rst_done got %0b/%0b exp 0/0", wr_done, rd_done); else passed++;
    aresetn = 1; cyc();
  endtask

  task automatic test_write_burst();
    aw(2, 3); cyc(); idle();
    total++; if (wr_outs !== 4'd1) $display("FAIL wb_outs1 got %0d exp 1", wr_outs); else passed++;
    bus.wvalid = 1; bus.wready = 0; cyc();
    for (int i = 0; i < 4; i++) begin wb(i == 3); cyc(); end
    idle(); b(2); cyc(); idle();
    total++; if (wr_done !== 1'b1) $display("FAIL wb_done got %0b exp 1", wr_done); else passed++;
    total++; if (wr_outs !== 4'd0) $display("FAIL wb_outs0 got %0d exp 0", wr_outs); else passed++;
    cyc();
    total++; if (wr_done !== 1'b0) $display("FAIL wb_done_once got %0b exp 0", wr_done); else passed++;
    total++; if (err !== 7'h00) $display("FAIL wb_err got %0h exp 0", err); else passed++;
  endtask

  task automatic test_wlast_errors();
    aw(0, 1); cyc(); idle(); wb(1); cyc(); idle();
    total++; if (err !== 7'h01) $display("FAIL early_err got %0h exp 1", err); else passed++;
    total++; if (err_pulse !== 1'b1) $display("FAIL early_pulse got %0b exp 1", err_pulse); else passed++;
    b(0); cyc(); idle();
    total++; if (err_pulse !== 1'b0 || wr_done !== 1'b1) $display("FAIL early_after got pulse=%0b done=%0b exp 0/1", err_pulse, wr_done); else passed++;
    clr();
    total++; if (err !== 7'h00) $display("FAIL early_clr got %0h exp 0", err); else passed++;
    aw(0, 0); cyc(); idle(); wb(0); cyc(); idle();
    total++; if (err !== 7'h02) $display("FAIL missing_err got %0h exp 2", err); else passed++;
    b(0); cyc(); idle(); clr();
    total++; if (wr_outs !== 4'd0 || err !== 7'h00) $display("FAIL missing_clean got outs=%0d err=%0h exp 0/0", wr_outs, err); else passed++;
  endtask

  task automatic test_read_interleave();
    ar(1, 1); cyc(); idle(); ar(3, 0); cyc(); idle();
    total++; if (rd_outs !== 7'd2) $display("FAIL ri_outs2 got %0d exp 2", rd_outs); else passed++;
    r(1, 0); cyc(); idle();
    total++; if (rd_done !== 1'b0) $display("FAIL ri_done0 got %0b exp 0", rd_done); else passed++;
    r(3, 1); cyc(); idle();
    total++; if (rd_done !== 1'b1 || rd_outs !== 7'd1) $display("FAIL ri_id3 got done=%0b outs=%0d exp 1/1", rd_done, rd_outs); else passed++;
    r(1, 1); cyc(); idle();
    total++; if (rd_done !== 1'b1 || rd_outs !== 7'd0) $display("FAIL ri_id1 got done=%0b outs=%0d exp 1/0", rd_done, rd_outs); else passed++;
    total++; if (err !== 7'h00) $display("FAIL ri_err got %0h exp 0", err); else passed++;
    ar(4, 1); cyc(); idle(); r(4, 1); cyc(); idle();
    total++; if (err !== 7'h20 || rd_outs !== 7'd0 || rd_done !== 1'b0) $display("FAIL rlast_mm got err=%0h outs=%0d done=%0b exp 20/0/0", err, rd_outs, rd_done); else passed++;
    clr();
  endtask

  task automatic test_same_cycle();
    b(5); cyc(); idle();
    total++; if (err !== 7'h08 || wr_done !== 1'b0) $display("FAIL bid_unexp got err=%0h done=%0b exp 8/0", err, wr_done); else passed++;
    clr();
    aw(5, 0); b(5); cyc(); idle();
    total++; if (err !== 7'h08 || wr_outs !== 4'd1) $display("FAIL aw_b_same got err=%0h outs=%0d exp 8/1", err, wr_outs); else passed++;
    wb(1); cyc(); idle(); b(5); cyc(); idle();
    total++; if (wr_done !== 1'b1 || wr_outs !== 4'd0) $display("FAIL aw_b_drain got done=%0b outs=%0d exp 1/0", wr_done, wr_outs); else passed++;
    clr();
    aw(1, 0); wb(1); cyc(); idle();
    total++; if (err !== 7'h04 || wr_outs !== 4'd1) $display("FAIL aw_w_same got err=%0h outs=%0d exp 4/1", err, wr_outs); else passed++;
    wb(1); cyc(); idle(); b(1); cyc(); idle();
    total++; if (err !== 7'h04 || wr_outs !== 4'd0) $display("FAIL aw_w_drain got err=%0h outs=%0d exp 4/0", err, wr_outs); else passed++;
    clr();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) begin aw(0, 0); cyc(); end
    total++; if (wr_outs !== 4'd8 || err !== 7'h00) $display("FAIL wovf_8 got outs=%0d err=%0h exp 8/0", wr_outs, err); else passed++;
    cyc(); idle();
    total++; if (wr_outs !== 4'd8 || err !== 7'h40) $display("FAIL wovf_9 got outs=%0d err=%0h exp 8/40", wr_outs, err); else passed++;
    for (int i = 0; i < 8; i++) begin wb(1); b(0); cyc(); end
    idle();
    total++; if (wr_outs !== 4'd0 || err !== 7'h40) $display("FAIL wovf_drain got outs=%0d err=%0h exp 0/40", wr_outs, err); else passed++;
    clr();
    for (int i = 0; i < 4; i++) begin ar(0, 0); cyc(); end
    total++; if (rd_outs !== 7'd4 || err !== 7'h00) $display("FAIL rovf_4 got outs=%0d err=%0h exp 4/0", rd_outs, err); else passed++;
    cyc(); idle();
    total++; if (rd_outs !== 7'd4 || err !== 7'h40) $display("FAIL rovf_5 got outs=%0d err=%0h exp 4/40", rd_outs, err); else passed++;
    for (int i = 0; i < 4; i++) begin r(0, 1); cyc(); end
    idle();
    total++; if (rd_outs !== 7'd0) $display("FAIL rovf_drain got %0d exp 0", rd_outs); else passed++;
    clr();
  endtask

  task automatic test_reset_mid();
    ar(2, 3); cyc(); idle(); r(2, 0); b(7); cyc(); idle();
    total++; if (rd_outs !== 7'd1 || err !== 7'h08) $display("FAIL rm_pre got outs=%0d err=%0h exp 1/8", rd_outs, err); else passed++;
    aresetn = 0; cyc(); aresetn = 1;
    total++; if (rd_outs !== 7'd0 || err !== 7'h00 || err_pulse !== 1'b0 || rd_done !== 1'b0)
      $display("FAIL rm_rst got outs=%0d err=%0h pulse=%0b done=%0b exp 0/0/0/0", rd_outs, err, err_pulse, rd_done); else passed++;
    r(2, 0); cyc(); idle();
    total++; if (err !== 7'h10 || err_pulse !== 1'b1) $display("FAIL rm_rid got err=%0h pulse=%0b exp 10/1", err, err_pulse); else passed++;
    r(2, 1); cyc(); idle();
    total++; if (err !== 7'h10 || err_pulse !== 1'b0 || rd_done !== 1'b0) $display("FAIL rm_rid2 got err=%0h pulse=%0b done=%0b exp 10/0/0", err, err_pulse, rd_done); else passed++;
  endtask

  initial begin
    idle(); aresetn = 0;
    test_reset();
    test_write_burst();
    test_wlast_errors();
    test_read_interleave();
    test_same_cycle();
    test_overflow();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/axi_txn_monitor.md
# axi_txn_monitor

Parametrised AXI4 transaction monitor that sits passively on a bridge's slave-side AXI interface, alongside the functional-coverage hookup, and probes the same signals. It tracks outstanding write and read bursts per ID and counts beats against `awlen`/`arlen`. It flags protocol violations in a sticky error vector, and publishes outstanding counts and per-burst completion pulses for scoreboards and coverage. It never drives the AXI bus.

## Interface
Parameters:
- `ID_W`, 4, AXI ID width.
- `LEN_W`, 8, burst length field width.
- `WR_OUTS`, 8, maximum outstanding write bursts in total.
- `RD_PER_ID`, 4, maximum outstanding read bursts per ID.

Ports:
- `aclk` in 1: the single clock. All logic is on the rising edge.
- `aresetn` in 1: reset, synchronous and active-low.
- `awvalid`, `awready` in 1; `awid` in ID_W; `awlen` in LEN_W: write address channel probe.
- `wvalid`, `wready`, `wlast` in 1: write data channel probe.
- `bvalid`, `bready` in 1; `bid` in ID_W: write response probe.
- `arvalid`, `arready` in 1; `arid` in ID_W; `arlen` in LEN_W: read address probe.
- `rvalid`, `rready`, `rlast` in 1; `rid` in ID_W: read data probe.
- `err_clear` in 1: synchronous clear of `err`.
- `err` out 7: sticky error flags. Bit indices are defined in the package.
- `err_pulse` out 1: high for one cycle whenever any error bit is newly set.
- `wr_outs` out $clog2(WR_OUTS+1): count of AW handshakes not yet matched by a B handshake.
- `rd_outs` out $clog2(RD_PER_ID*2**ID_W+1): count of AR handshakes not yet completed by an R last beat.
- `wr_done` out 1: one-cycle pulse after a B handshake that matches an outstanding write.
- `rd_done` out 1: one-cycle pulse after a matched R handshake with `rlast` high.

## Operation
- A handshake on a channel is `valid & ready` sampled at the rising edge. No other signal levels are interpreted.
- **Write path**
  - On an AW handshake, push `awlen` into the in-order write FIFO (depth WR_OUTS) and increment `bpend[awid]`.
  - On a W handshake with the FIFO non-empty, compare the beat counter `wbeat` with the head length.
  - `wbeat < len` with `wlast=1`: set WLAST_EARLY, pop the head, clear `wbeat`.
  - `wbeat == len` with `wlast=0`: set WLAST_MISSING, pop the head, clear `wbeat`.
  - `wbeat == len` with `wlast=1`: pop the head, clear `wbeat`.
  - Otherwise: `wbeat++`.
  - A W handshake with the FIFO empty sets W_NO_AW. W data arriving before its AW is unsupported; that beat is ignored.
  - On a B handshake with `bpend[bid] > 0`: decrement `bpend[bid]`, pulse `wr_done`.
  - On a B handshake with `bpend[bid] == 0`: set BID_UNEXP.
- **Read path**
  - Each ID has a circular length buffer of depth RD_PER_ID with its own beat counter `rbeat[id]`. Read interleaving across IDs is legal; within an ID, responses are in order.
  - On an AR handshake, push `arlen` into `buf[arid]`.
  - On an R handshake, if `buf[rid]` is empty, set RID_UNEXP.
  - Otherwise, if `rlast != (rbeat[rid] == len)`, set RLAST_MISMATCH and pop.
  - Otherwise, on the last beat, pop and pulse `rd_done`.
  - On any non-last beat with no error, `rbeat[rid]++`.
  - Every pop clears `rbeat[rid]`.
- **Overflow**
  - An AW handshake while the write FIFO is full sets OVERFLOW and is dropped: no push, no `bpend` increment.
  - An AR handshake while `buf[arid]` is full sets OVERFLOW and is dropped.
- **Simultaneous events**
  - AW and W in the same cycle with the FIFO empty: W is checked against the pre-edge FIFO, so W_NO_AW is set.
  - AW and B in the same cycle on the same ID: B is checked against the pre-edge `bpend`. A net-zero update is legal.
  - AR and R in the same cycle on the same ID: R is checked against the pre-edge buffer.
  - Push and pop on a full FIFO in the same cycle: the push is accepted only if the FIFO was not full pre-edge.
- **Errors**
  - `err` bits are set-only until `err_clear`.
  - If a set and `err_clear` occur in the same cycle, the set wins.
  - `err_pulse` = OR of the bits newly set this cycle, registered.

## Timing
- All outputs are registered and reflect the handshakes of cycle N at cycle N+1.
- No combinational path from any input to any output.
- While `aresetn=0` at an edge: FIFOs, per-ID buffers, beat counters, `bpend`, `err`, `err_pulse`, `wr_done`, `rd_done`, `wr_outs` and `rd_outs` all reset to 0.
- Reset asserted mid-burst discards all tracking state. The first handshakes after reset are treated as fresh traffic.
- `wr_outs` and `rd_outs` update with net change per cycle: +1, 0 or −1.
- Beat counters are LEN_W bits and never wrap, because they clear at len.

## Structure
- Package `axi_mon_pkg`:
  - Error bit indices `ERR_WLAST_EARLY`=0, `ERR_WLAST_MISSING`=1, `ERR_W_NO_AW`=2, `ERR_BID_UNEXP`=3, `ERR_RID_UNEXP`=4, `ERR_RLAST_MISMATCH`=5, `ERR_OVERFLOW`=6.
  - `ERR_W`=7.
- Sub-module `axi_len_fifo`:
  - Parameters DEPTH and WIDTH; push/pop, `full`, `empty`, `head` outputs.
  - Instantiated once for the write path and `2**ID_W` times in a generate loop for the read buffers.

## Test plan
- AW id=2 len=3, 4 W beats with `wlast` on beat 4, then B id=2 → `wr_done` pulses once, `wr_outs` goes 1→0, `err`=0.
- AW len=1, W with `wlast` on beat 1 → ERR_WLAST_EARLY set, `err_pulse` high for 1 cycle. Asserting `err_clear` then clears it.
- AR id=1 len=1 and AR id=3 len=0, then R beats interleaved id=1, id=3(last), id=1(last) → two `rd_done` pulses, `rd_outs` 2→0, no error.
- B id=5 with no AW outstanding → ERR_BID_UNEXP set. An AW id=5 in the same cycle as that B still gives the error, and `wr_outs` ends at 1.
- 9 back-to-back AWs with WR_OUTS=8 → ERR_OVERFLOW set on the 9th, `wr_outs` holds at 8. 5 ARs on id=0 → overflow on the 5th.
- `aresetn` low mid-read-burst → all outputs 0 next cycle. Remaining R beats then give ERR_RID_UNEXP.
